// File: rtl/mem_pkg.sv
// mem_pkg: shared access-size and FSM-state encodings for the memory-access stage
package mem_pkg;
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    typedef enum logic {IDLE, ACCESS} memState;
endpackage

// File: rtl/mem_access_if.sv
// mem_access_if: data-memory req/ack bus; master = mem_access stage, slave = memory
//   dmem_req/we/addr/be/wdata : request, held stable until dmem_ack
//   dmem_ack/rdata            : completion, read word valid with ack
interface mem_access_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              dmem_req;
    logic              dmem_we;
    logic [ADDR_W-1:0] dmem_addr;
    logic [3:0]        dmem_be;
    logic [DATA_W-1:0] dmem_wdata;
    logic              dmem_ack;
    logic [DATA_W-1:0] dmem_rdata;
    modport master(output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata, input dmem_ack, dmem_rdata);
    modport slave(input dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata, output dmem_ack, dmem_rdata);
endinterface

// File: rtl/mem_load_align.sv
// mem_load_align: selects a big-endian byte/half lane from a read word and zero/sign-extends it
//   rdata    : read word          offset : byte offset within the word
//   size     : access size        isSigned : sign-extend sub-word results
//   result   : extended 32-bit load value
module mem_load_align
    import mem_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  logic [1:0]  size,
    input  logic        isSigned,
    output logic [31:0] result
);
    logic [7:0]  byteLane;
    logic [15:0] halfLane;
    // offset 0 is the most significant byte, so the lane base is (3 - offset) * 8
    assign byteLane = rdata[{~offset, 3'b000} +: 8];
    assign halfLane = offset[1] ? rdata[15:0] : rdata[31:16];
    always_comb begin
        result = rdata;
        result = (size == SZ_BYTE) ? {{24{isSigned & byteLane[7]}}, byteLane}
               : (size == SZ_HALF) ? {{16{isSigned & halfLane[15]}}, halfLane}
               : rdata;
    end
endmodule

// File: rtl/mem_access.sv
// mem_access: DLX memory stage; runs one load/store per op over a req/ack port, else passes the ALU result
//   clk, rst_n            : clock, synchronous active-low reset
//   ex_valid/ex_ready     : op handshake from execute (ready only when idle)
//   alu_res, store_data   : effective address / result, right-justified store operand
//   mem_rd, mem_wr, size, load_signed, rd_in, reg_wr_in : op controls
//   dmem                  : data-memory bus (master side)
//   wb_valid/wb_data/wb_rd/wb_reg_wr/misaligned : one-cycle write-back result
module mem_access
    import mem_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ex_valid,
    output logic              ex_ready,
    input  logic [ADDR_W-1:0] alu_res,
    input  logic [DATA_W-1:0] store_data,
    input  logic              mem_rd,
    input  logic              mem_wr,
    input  logic [1:0]        size,
    input  logic              load_signed,
    input  logic [4:0]        rd_in,
    input  logic              reg_wr_in,
    mem_access_if.master      dmem,
    output logic              wb_valid,
    output logic [DATA_W-1:0] wb_data,
    output logic [4:0]        wb_rd,
    output logic              wb_reg_wr,
    output logic              misaligned
);
    memState           state, stateNext;
    logic              xfer, isMem, fault;
    logic [1:0]        off, sz, offL, sizeL;
    logic [3:0]        be;
    logic [DATA_W-1:0] wdata, loadData;
    logic              signL, regWrL;
    logic [4:0]        rdL;

    assign ex_ready = rst_n & (state == IDLE);
    assign xfer     = ex_valid & ex_ready;
    assign isMem    = mem_rd | mem_wr;
    assign off      = alu_res[1:0];
    assign sz       = (size == 2'b11) ? SZ_WORD : size;

    always_comb begin
        fault = 1'b0;
        fault = isMem & ((sz == SZ_HALF) ? off[0] : (sz == SZ_WORD) ? (off != 2'b00) : 1'b0);
        be    = (sz == SZ_BYTE) ? (4'b1000 >> off) : (sz == SZ_HALF) ? (off[1] ? 4'b0011 : 4'b1100) : 4'b1111;
        wdata = (sz == SZ_BYTE) ? {4{store_data[7:0]}} : (sz == SZ_HALF) ? {2{store_data[15:0]}} : store_data;
    end

    always_comb begin
        stateNext = state;
        stateNext = (state == IDLE) ? ((xfer & isMem & ~fault) ? ACCESS : IDLE)
                  : (dmem.dmem_ack ? IDLE : ACCESS);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= stateNext;
    end

    mem_load_align uAlign (
        .rdata   (dmem.dmem_rdata),
        .offset  (offL),
        .size    (sizeL),
        .isSigned(signL),
        .result  (loadData)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dmem.dmem_req   <= 1'b0;
            dmem.dmem_we    <= 1'b0;
            dmem.dmem_addr  <= '0;
            dmem.dmem_be    <= '0;
            dmem.dmem_wdata <= '0;
            wb_valid        <= 1'b0;
            wb_data         <= '0;
            wb_rd           <= '0;
            wb_reg_wr       <= 1'b0;
            misaligned      <= 1'b0;
            offL            <= '0;
            sizeL           <= '0;
            signL           <= 1'b0;
            rdL             <= '0;
            regWrL          <= 1'b0;
        end else begin
            wb_valid <= 1'b0;
            if (xfer) begin
                if (!isMem || fault) begin
                    wb_valid   <= 1'b1;
                    wb_data    <= alu_res;
                    wb_rd      <= rd_in;
                    wb_reg_wr  <= reg_wr_in & ~isMem;
                    misaligned <= isMem;
                end else begin
                    dmem.dmem_req   <= 1'b1;
                    dmem.dmem_we    <= mem_wr;
                    dmem.dmem_addr  <= {alu_res[ADDR_W-1:2], 2'b00};
                    dmem.dmem_be    <= be;
                    dmem.dmem_wdata <= wdata;
                    offL            <= off;
                    sizeL           <= sz;
                    signL           <= load_signed;
                    rdL             <= rd_in;
                    regWrL          <= reg_wr_in;
                end
            end else if (state == ACCESS && dmem.dmem_ack) begin
                // dmem_we doubles as the latched "this op is a store" flag
                dmem.dmem_req <= 1'b0;
                wb_valid      <= 1'b1;
                wb_data       <= dmem.dmem_we ? '0 : loadData;
                wb_rd         <= rdL;
                wb_reg_wr     <= regWrL & ~dmem.dmem_we;
                misaligned    <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: randomized scoreboard bench for mem_access against a byte-addressed reference memory
module tb_mem_access;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid, ex_ready, mem_rd, mem_wr, load_signed, reg_wr_in;
    logic [31:0] alu_res, store_data, wb_data;
    logic [1:0]  size;
    logic [4:0]  rd_in, wb_rd;
    logic        wb_valid, wb_reg_wr, misaligned;

    always #5 clk = ~clk;

    mem_access_if #(.ADDR_W(32), .DATA_W(32)) dmem();

    mem_access dut (
        .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_ready(ex_ready),
        .alu_res(alu_res), .store_data(store_data), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .size(size), .load_signed(load_signed), .rd_in(rd_in), .reg_wr_in(reg_wr_in),
        .dmem(dmem), .wb_valid(wb_valid), .wb_data(wb_data), .wb_rd(wb_rd),
        .wb_reg_wr(wb_reg_wr), .misaligned(misaligned)
    );

    typedef struct {
        logic [31:0] data;
        logic [4:0]  rd;
        bit          regWr, mis, isMem, chkData, chkRd;
        int          due;
    } wbExp;
    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        int          dly;
    } reqExp;

    wbExp        wbQ[$];
    reqExp       reqQ[$];
    int          checks = 0, errors = 0, cyc = 0, ackDue = 0;
    bit          lateAck = 0;
    logic [7:0]  refBytes[2048];
    logic [31:0] respMem[512];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic void setWord(input int a, input logic [31:0] v);
        for (int k = 0; k < 4; k++) refBytes[a + k] = v[31 - 8 * k -: 8];
        respMem[a / 4] = v;
    endfunction

    // Reference model: memory is a big-endian byte array; an n-byte access at address a
    // covers bytes a..a+n-1, most significant first, and is aligned iff a % n == 0.
    task automatic issue(input bit rd, input bit wr, input logic [1:0] sz, input bit sgn,
                         input logic [31:0] a, input logic [31:0] sd, input logic [4:0] rdIn,
                         input bit rw, input int dly, input bit expWb);
        int n, off, t;
        bit isMemOp, mis;
        wbExp e;
        reqExp r;
        logic [31:0] v;
        n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        isMemOp = rd | wr;
        off = int'(a % 4);
        mis = isMemOp && (a % n != 0);
        mem_rd = rd; mem_wr = wr; size = sz; load_signed = sgn;
        alu_res = a; store_data = sd; rd_in = rdIn; reg_wr_in = rw; ex_valid = 1'b1;
        t = 0;
        while (ex_ready !== 1'b1 && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (ex_ready !== 1'b1) begin
            chk(0, "ex_ready_timeout", 32'(ex_ready), 32'd1);
            ex_valid = 1'b0;
            return;
        end
        e.due = cyc + 1;
        e.isMem = isMemOp && !mis;
        e.rd = rdIn;
        e.chkRd = !mis;
        e.chkData = !mis;
        e.mis = mis;
        e.regWr = (isMemOp && (mis || wr)) ? 1'b0 : rw;
        e.data = a;
        if (isMemOp && !mis) begin
            r.we = wr;
            r.addr = {a[31:2], 2'b00};
            r.be = 4'b0000;
            for (int k = 0; k < n; k++) r.be[3 - (off + k)] = 1'b1;
            r.wdata = (n == 1) ? {4{sd[7:0]}} : (n == 2) ? {2{sd[15:0]}} : sd;
            r.dly = dly;
            if (wr) begin
                for (int k = 0; k < n; k++) refBytes[int'(a) + k] = sd[8 * (n - 1 - k) +: 8];
                e.data = 32'd0;
            end else begin
                v = 32'd0;
                for (int k = 0; k < n; k++) v = (v << 8) | 32'(refBytes[int'(a) + k]);
                if (sgn && n < 4 && v[8 * n - 1]) v = v | ~((32'd1 << (8 * n)) - 32'd1);
                e.data = v;
            end
            reqQ.push_back(r);
        end
        if (expWb) wbQ.push_back(e);
        @(negedge clk);
        ex_valid = 1'b0;
    endtask

    // Memory responder: checks each new request against the model, holds ack off for the
    // chosen delay while checking the request stays stable, and fires stray acks when idle.
    bit          reqActive = 0, hold = 0;
    int          cnt = 0;
    logic        lWe;
    logic [31:0] lAddr, lWdata;
    logic [3:0]  lBe;
    reqExp       rq;
    always @(negedge clk) begin
        if (dmem.dmem_req === 1'b1) begin
            if (!reqActive) begin
                reqActive = 1;
                lWe = dmem.dmem_we; lAddr = dmem.dmem_addr; lBe = dmem.dmem_be; lWdata = dmem.dmem_wdata;
                if (reqQ.size() == 0) begin
                    chk(0, "unexpected_req", dmem.dmem_addr, 32'd0);
                    cnt = 0;
                    hold = 0;
                end else begin
                    rq = reqQ.pop_front();
                    chk(dmem.dmem_we === rq.we, "req_we", 32'(dmem.dmem_we), 32'(rq.we));
                    chk(dmem.dmem_addr === rq.addr, "req_addr", dmem.dmem_addr, rq.addr);
                    chk(dmem.dmem_be === rq.be, "req_be", 32'(dmem.dmem_be), 32'(rq.be));
                    if (rq.we) chk(dmem.dmem_wdata === rq.wdata, "req_wdata", dmem.dmem_wdata, rq.wdata);
                    hold = (rq.dly == -2);
                    cnt = (rq.dly >= 0) ? rq.dly : int'($urandom_range(0, 3));
                end
            end else begin
                chk(dmem.dmem_we === lWe && dmem.dmem_addr === lAddr && dmem.dmem_be === lBe &&
                    dmem.dmem_wdata === lWdata, "req_stable", dmem.dmem_addr, lAddr);
            end
            chk(ex_ready === 1'b0, "ex_ready_busy", 32'(ex_ready), 32'd0);
            if (!hold && cnt <= 0) begin
                dmem.dmem_ack = 1'b1;
                dmem.dmem_rdata = respMem[lAddr[10:2]];
                if (lWe) for (int i = 0; i < 4; i++) if (lBe[i]) respMem[lAddr[10:2]][8 * i +: 8] = lWdata[8 * i +: 8];
                ackDue = cyc + 1;
            end else begin
                dmem.dmem_ack = 1'b0;
                dmem.dmem_rdata = $urandom;
                cnt--;
            end
        end else begin
            reqActive = 0;
            dmem.dmem_ack = lateAck | ($urandom_range(0, 1) == 1);
            dmem.dmem_rdata = $urandom;
        end
    end

    // Write-back monitor
    wbExp we;
    int   want;
    always @(negedge clk) begin
        if (wb_valid === 1'b1) begin
            if (wbQ.size() == 0) chk(0, "unexpected_wb", wb_data, 32'd0);
            else begin
                we = wbQ.pop_front();
                want = we.isMem ? ackDue : we.due;
                chk(cyc == want, "wb_timing", 32'(cyc), 32'(want));
                if (we.chkData) chk(wb_data === we.data, "wb_data", wb_data, we.data);
                if (we.chkRd) chk(wb_rd === we.rd, "wb_rd", 32'(wb_rd), 32'(we.rd));
                chk(wb_reg_wr === we.regWr, "wb_reg_wr", 32'(wb_reg_wr), 32'(we.regWr));
                chk(misaligned === we.mis, "misaligned", 32'(misaligned), 32'(we.mis));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int k, gap, t;
        logic [1:0] s;
        rst_n = 1'b0; ex_valid = 1'b0; mem_rd = 1'b0; mem_wr = 1'b0; size = 2'd0; load_signed = 1'b0;
        alu_res = '0; store_data = '0; rd_in = '0; reg_wr_in = 1'b0;
        for (int i = 0; i < 512; i++) setWord(i * 4, $urandom);
        repeat (3) @(negedge clk);
        chk(ex_ready === 1'b0, "rst_ex_ready", 32'(ex_ready), 32'd0);
        chk(dmem.dmem_req === 1'b0 && dmem.dmem_we === 1'b0, "rst_req_we", 32'(dmem.dmem_req), 32'd0);
        chk(dmem.dmem_addr === 32'd0 && dmem.dmem_be === 4'd0 && dmem.dmem_wdata === 32'd0, "rst_bus", dmem.dmem_addr, 32'd0);
        chk(wb_valid === 1'b0 && wb_data === 32'd0 && wb_rd === 5'd0 && wb_reg_wr === 1'b0 && misaligned === 1'b0,
            "rst_wb", wb_data, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        issue(0, 0, 2'd2, 0, 32'h0000_1234, 32'd0, 5'd5, 1, -1, 1);
        setWord(32'h100, 32'h1122_3380);
        issue(1, 0, 2'd0, 1, 32'h0000_0103, 32'd0, 5'd7, 1, 3, 1);
        setWord(32'h200, 32'hAAAA_8001);
        issue(1, 0, 2'd1, 0, 32'h0000_0202, 32'd0, 5'd8, 1, 0, 1);
        issue(0, 1, 2'd0, 0, 32'h0000_0301, 32'h0000_00AB, 5'd9, 1, -1, 1);
        issue(1, 0, 2'd2, 0, 32'h0000_0402, 32'd0, 5'd10, 1, -1, 1);
        issue(1, 0, 2'd2, 0, 32'h0000_0500, 32'd0, 5'd11, 1, -2, 0);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        lateAck = 1;
        @(negedge clk);
        chk(dmem.dmem_req === 1'b0, "abort_req", 32'(dmem.dmem_req), 32'd0);
        chk(ex_ready === 1'b0, "abort_ex_ready", 32'(ex_ready), 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk(wb_valid === 1'b0 && dmem.dmem_req === 1'b0, "late_ack_ignored", 32'(wb_valid), 32'd0);
            chk(ex_ready === 1'b1, "abort_ready_back", 32'(ex_ready), 32'd1);
        end
        lateAck = 0;
        for (int i = 0; i < 400; i++) begin
            k = int'($urandom_range(0, 9));
            s = 2'($urandom_range(0, 3));
            issue((k >= 3 && k <= 5) || k == 9, k >= 6, s, 1'($urandom_range(0, 1)),
                  (k < 3) ? 32'($urandom) : 32'($urandom_range(0, 2047)), 32'($urandom),
                  5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), -1, 1);
            gap = int'($urandom_range(0, 3));
            if (gap > 1) repeat (gap - 1) @(negedge clk);
        end
        t = 0;
        while ((wbQ.size() != 0 || reqQ.size() != 0) && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (wbQ.size() != 0 || reqQ.size() != 0) chk(0, "drain_timeout", 32'(wbQ.size()), 32'(reqQ.size()));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_access.md
# mem_access

Memory-access stage directly downstream of the execute stage in the DLX datapath. Accepts the ALU result as an effective address plus the store operand. Runs one load or store against a variable-latency data-memory port using a req/ack handshake, stalling execute while the access is outstanding. Delivers aligned, extended load data, or the passed-through ALU result, to write-back.

## Interface
- `ADDR_W`, default 32: address width.
- `DATA_W`, default 32: data width; byte-lane logic assumes 32.
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  reset is synchronous and active-low.
- `ex_valid`  in  1  execute presents an operation.
- `ex_ready`  out  1  stage can accept; transfer when `ex_valid & ex_ready`.
- `alu_res`  in  32  effective address, or result for non-memory ops.
- `store_data`  in  32  busB value to store; right-justified.
- `mem_rd`, `mem_wr`  in  1 each  load / store select.
- `size`  in  2  00 byte, 01 half, 10 word; 11 treated as word.
- `load_signed`  in  1  sign-extend sub-word loads.
- `rd_in`  in  5  destination register.
- `reg_wr_in`  in  1  destination write enable.
- `dmem_req`  out  1  memory request; held until ack.
- `dmem_we`  out  1  write request.
- `dmem_addr`  out  32  word-aligned address (`alu_res & ~3`).
- `dmem_be`  out  4  byte enables; bit 3 = bits [31:24].
- `dmem_wdata`  out  32  lane-replicated store data.
- `dmem_ack`  in  1  access complete; `dmem_rdata` valid this cycle.
- `dmem_rdata`  in  32  read word.
- `wb_valid`  out  1  one-cycle pulse: result for write-back.
- `wb_data`  out  32  load data or ALU result.
- `wb_rd`  out  5  destination register.
- `wb_reg_wr`  out  1  write enable; forced 0 on misalignment.
- `misaligned`  out  1  alignment fault; valid with `wb_valid`.

## Operation
- Big-endian: byte offset 0 maps to bits [31:24]; offset 3 maps to bits [7:0].
- FSM states: IDLE and ACCESS. `ex_ready = rst_n & (state == IDLE)`.
- IDLE with a transfer and no memory op: on the next edge, `wb_valid`=1, `wb_data`=`alu_res`, and `wb_rd`/`wb_reg_wr` come from the inputs. State stays IDLE.
- IDLE with a transfer and a memory op:
  - Alignment fault: half with `addr[0]`=1, or word with `addr[1:0]`≠0.
  - On a fault, no request is issued. On the next edge, `wb_valid`=1, `misaligned`=1, `wb_reg_wr`=0.
  - Without a fault, latch address, byte enables, write data, size, sign and destination, then go to ACCESS.
- `mem_rd & mem_wr` both set: treated as a store.
- ACCESS:
  - `dmem_req`=1 and all `dmem_*` outputs stay stable until `dmem_ack`.
  - On ack: go to IDLE and pulse `wb_valid`.
  - Load: `wb_data` = the selected lane, zero- or sign-extended.
  - Store: `wb_reg_wr`=0 and `wb_data`=0.
- Byte enables:
  - Byte: `1000 >> offset`.
  - Half: offset 0 gives 1100; offset 2 gives 0011.
  - Word: 1111.
- Store data:
  - Byte is replicated in all 4 lanes.
  - Half is replicated in both halves.
  - Word is passed through unchanged.
- `dmem_ack` outside ACCESS is ignored.
- `misaligned` is 0 on every pulse except a faulted one.

## Timing
- Reset values: `dmem_req`, `dmem_we` = 0; `dmem_addr`, `dmem_be`, `dmem_wdata` = 0; `wb_valid`, `wb_data`, `wb_rd`, `wb_reg_wr`, `misaligned` = 0; state IDLE; `ex_ready`=0 while `rst_n`=0.
- Non-memory or faulted op: latency 1. Transfer at edge N, `wb_valid` high in cycle N+1.
- Memory op:
  - Transfer at edge N; `dmem_req` high from cycle N+1.
  - Ack in cycle N+k gives `wb_valid` in cycle N+k+1. Minimum latency 2 (ack in first request cycle).
- Back-to-back ops: a new transfer can occur in the same cycle `wb_valid` is high.
- `wb_valid` is a single-cycle pulse; write-back never back-pressures.
- Reset asserted during ACCESS: request dropped at that edge, no `wb_valid`, and a later ack is ignored. Memory must tolerate abandoned requests.
- All outputs are registered except `ex_ready`.

## Structure
- Shared package `mem_pkg`:
  - size encodings `SZ_BYTE`=2'b00, `SZ_HALF`=2'b01, `SZ_WORD`=2'b10;
  - state encoding IDLE/ACCESS.
- Sub-module `mem_load_align` (combinational): inputs are the read word, offset, size and sign; output is the extended 32-bit result. It is reusable by a future cache fill path.
- Store lane and byte-enable generation stay in the top module.

## Test plan
- ALU op, `alu_res`=0x0000_1234, `rd_in`=5 -> next cycle `wb_valid`=1, `wb_data`=0x1234, `wb_rd`=5, no `dmem_req`.
- Signed byte load at 0x103, memory returns 0x1122_3380, ack after 3 request cycles -> `dmem_addr`=0x100, `dmem_be`=0001, `ex_ready`=0 throughout, `wb_data`=0xFFFF_FF80.
- Unsigned half load at 0x202, rdata 0xAAAA_8001, ack in first request cycle -> `dmem_be`=0011, `wb_data`=0x0000_8001, latency 2.
- Byte store 0x0000_00AB at 0x301 -> `dmem_we`=1, `dmem_be`=0100, `dmem_wdata`=0xABAB_ABAB, `wb_reg_wr`=0.
- Word load at 0x402 -> no request, `wb_valid`=1, `misaligned`=1, `wb_reg_wr`=0 next cycle.
- Load at 0x500 with no ack for 4 cycles, then `rst_n`=0 for one cycle -> `dmem_req`=0 after that edge, no `wb_valid`, a late ack is ignored, and `ex_ready` returns to 1.
